// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source interrupt controller with software mask, fixed
// lowest-index-first priority, request/acknowledge handshake to the CPU and
// end-of-interrupt (EOI) release of the in-service source.
//
// Optional feature macro: IRQC_EDGE_EN
//   defined   - sources are rising-edge detected into a sticky PEND register
//               (write-1-to-clear, cleared for the winner at the ack edge)
//   undefined - PEND is the live intr_in level, no storage
//
// Handshake: irq_req is high from the edge that enters REQ until the edge that
// samples irq_ack=1; irq_id is stable for that whole span and through SERVICE.
// irq_ack outside REQ and EOI writes outside SERVICE have no effect.
//
// Ports
//   clk      in   system clock, rising edge
//   clr      in   asynchronous active-low reset
//   addr     in   [31:0] bus byte address, window BASE..BASE+0xF
//   WD       in   [31:0] bus write data
//   WE       in   bus write enable (only acts inside the window)
//   RD       out  [31:0] combinational read data, 0 outside the window
//   intr_in  in   [N_SRC-1:0] interrupt sources, active-high
//   irq_req  out  interrupt request to CPU
//   irq_id   out  [2:0] requested / in-service source index
//   irq_ack  in   single-cycle CPU acknowledge
//
// Register map (addr[3:2]): 0 MASK (RW), 1 PEND (R, W1C in edge mode),
//   2 VEC (R: bit31 = in service, bits[2:0] = irq_id), 3 EOI (W, reads 0)
module irq_ctrl #(
   parameter int          N_SRC = 6,
   parameter logic [31:0] BASE  = 32'h00007F20
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [31:0]      addr,
   input  logic [31:0]      WD,
   input  logic             WE,
   output logic [31:0]      RD,
   input  logic [N_SRC-1:0] intr_in,
   output logic             irq_req,
   output logic [2:0]       irq_id,
   input  logic             irq_ack
);

   localparam logic [1:0] REG_MASK = 2'd0;
   localparam logic [1:0] REG_PEND = 2'd1;
   localparam logic [1:0] REG_VEC  = 2'd2;
   localparam logic [1:0] REG_EOI  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e           state_q;
   logic             irq_req_q;
   logic [2:0]       irq_id_q;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] elig;
   logic [2:0]       winner;
   logic             in_win, wr_en, eoi_wr;
   logic [1:0]       sel;

   assign in_win = (addr[31:4] == BASE[31:4]);
   assign sel    = addr[3:2];
   assign wr_en  = WE & in_win;
   assign eoi_wr = wr_en && (sel == REG_EOI);

   // Byte-lane bits and unused data bits are not decoded.
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], WD[31:N_SRC]};

   // ---------------- Mask register ----------------
   assign mask_d = (wr_en && sel == REG_MASK) ? WD[N_SRC-1:0] : mask_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) mask_q <= '0;
      else      mask_q <= mask_d;
   end

   // ---------------- Pending sources ----------------
`ifdef IRQC_EDGE_EN
   logic [N_SRC-1:0] intr_prev_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] pend_set, pend_clr;

   always_comb begin
      pend_set = intr_in & ~intr_prev_q;
      pend_clr = (wr_en && sel == REG_PEND) ? WD[N_SRC-1:0] : '0;
      // The acknowledged source is consumed at the ack edge.
      for (int i = 0; i < N_SRC; i++) begin
         if (state_q == ST_REQ && irq_ack && irq_id_q == 3'(i)) pend_clr[i] = 1'b1;
      end
      // A fresh rising edge beats a simultaneous clear of the same bit.
      pend_d = (pend_q & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         intr_prev_q <= '0;
         pend_q      <= '0;
      end else begin
         intr_prev_q <= intr_in;
         pend_q      <= pend_d;
      end
   end

   assign pend = pend_q;
`else
   assign pend = intr_in;
`endif

   assign elig = pend & mask_q;

   // Lowest set index wins: scan downward so the last hit is the lowest.
   always_comb begin
      winner = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig[i]) winner = 3'(i);
      end
   end

   // ---------------- Handshake FSM ----------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= ST_IDLE;
         irq_req_q <= 1'b0;
         irq_id_q  <= 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (elig != '0) begin
                  state_q   <= ST_REQ;
                  irq_req_q <= 1'b1;
                  irq_id_q  <= winner;
               end
            end
            ST_REQ: begin
               // Ack takes precedence over a withdrawal in the same cycle.
               if (irq_ack) begin
                  state_q   <= ST_SERVICE;
                  irq_req_q <= 1'b0;
               end else if (!elig[irq_id_q]) begin
                  state_q   <= ST_IDLE;
                  irq_req_q <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (eoi_wr) state_q <= ST_IDLE;
            end
            default: begin
               state_q   <= ST_IDLE;
               irq_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req = irq_req_q;
   assign irq_id  = irq_id_q;

   // ---------------- Read mux ----------------
   always_comb begin
      RD = 32'd0;
      if (in_win) begin
         case (sel)
            REG_MASK: RD[N_SRC-1:0] = mask_q;
            REG_PEND: RD[N_SRC-1:0] = pend;
            REG_VEC:  RD = {(state_q == ST_SERVICE), 28'd0, irq_id_q};
            default:  RD = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every falling edge against a behavioural model.
module tb_irq_ctrl;

  localparam logic [31:0] BASE   = 32'h00007F20;
  localparam logic [31:0] A_MASK = BASE + 32'h0;
  localparam logic [31:0] A_PEND = BASE + 32'h4;
  localparam logic [31:0] A_VEC  = BASE + 32'h8;
  localparam logic [31:0] A_EOI  = BASE + 32'hC;
  localparam logic [31:0] A_OFF  = 32'h00000000;

`ifdef IRQC_EDGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] addr = A_OFF;
  logic [31:0] wd = 32'd0;
  logic        we = 1'b0;
  logic [31:0] rd;
  logic [5:0]  intr_in = 6'd0;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack = 1'b0;

  always #10 clk = ~clk;

  irq_ctrl dut (
    .clk     (clk),
    .clr     (clr),
    .addr    (addr),
    .WD      (wd),
    .WE      (we),
    .RD      (rd),
    .intr_in (intr_in),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .irq_ack (irq_ack)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0] m_mask, m_pend, m_prev;
  bit         m_req, m_svc;
  logic [2:0] m_id;

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'hF);
  endfunction

  function automatic logic [5:0] cur_pend();
`ifdef IRQC_EDGE_EN
    return m_pend;
`else
    return intr_in;
`endif
  endfunction

  function automatic logic [2:0] lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (!in_window(a)) return 32'd0;
    case (a[3:2])
      2'd0:    return {26'd0, m_mask};
      2'd1:    return {26'd0, cur_pend()};
      2'd2:    return (m_svc ? 32'h80000000 : 32'd0) + {29'd0, m_id};
      default: return 32'd0;
    endcase
  endfunction

  logic [5:0] t_elig, t_clr;
  bit         t_wr, t_ack_hit;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_mask = 6'd0; m_pend = 6'd0; m_prev = 6'd0;
      m_req = 0; m_svc = 0; m_id = 3'd0;
    end else begin
      t_elig    = cur_pend() & m_mask;
      t_wr      = we && in_window(addr);
      t_ack_hit = 0;
      if (m_req) begin
        if (irq_ack) begin m_req = 0; m_svc = 1; t_ack_hit = 1; end
        else if (!t_elig[m_id]) m_req = 0;
      end else if (m_svc) begin
        if (t_wr && addr[3:2] == 2'd3) m_svc = 0;
      end else if (t_elig != 0) begin
        m_req = 1; m_id = lowest(t_elig);
      end
`ifdef IRQC_EDGE_EN
      t_clr = (t_wr && addr[3:2] == 2'd1) ? wd[5:0] : 6'd0;
      if (t_ack_hit) t_clr[m_id] = 1'b1;
      m_pend = (m_pend & ~t_clr) | (intr_in & ~m_prev);
      m_prev = intr_in;
`endif
      if (t_wr && addr[3:2] == 2'd0) m_mask = wd[5:0];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("irq_req", {31'd0, irq_req}, {31'd0, m_req});
    check("irq_id", {29'd0, irq_id}, {29'd0, m_id});
    check("RD", rd, model_rd(addr));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1'b1;
    tick(1);
    we = 1'b0; addr = A_OFF;
  endtask

  task automatic check_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rd, exp);
    addr = A_OFF;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3;
    check("reset_req", {31'd0, irq_req}, 32'd0);
    check("reset_id", {29'd0, irq_id}, 32'd0);
    check_rd("reset_mask", A_MASK, 32'd0);
    tick(2);
    clr = 1'b1;
    tick(1);

    // Priority: two sources, lowest index first, then next one after EOI.
    bus_write(A_MASK, 32'h3F);
    intr_in = 6'b100100;
    tick(LAT);
    check("prio_req", {31'd0, irq_req}, 32'd1);
    check("prio_id2", {29'd0, irq_id}, 32'd2);
    do_ack();
    check("ack_drops_req", {31'd0, irq_req}, 32'd0);
    check_rd("vec_service", A_VEC, 32'h80000002);
    intr_in = 6'b100000;
    bus_write(A_EOI, 32'h0);
    check("eoi_gap", {31'd0, irq_req}, 32'd0);
    tick(1);
    check("next_req", {31'd0, irq_req}, 32'd1);
    check("next_id5", {29'd0, irq_id}, 32'd5);
    intr_in = 6'd0;
    do_ack();
    bus_write(A_EOI, 32'h0);

    // Masking: masked source stays pending only.
    bus_write(A_MASK, 32'h01);
    intr_in = 6'b000010;
    tick(LAT + 1);
    check("masked_noreq", {31'd0, irq_req}, 32'd0);
    check_rd("masked_pend", A_PEND, 32'h02);
    bus_write(A_MASK, 32'h03);
    tick(1);
    check("unmask_req", {31'd0, irq_req}, 32'd1);
    check("unmask_id1", {29'd0, irq_id}, 32'd1);
    intr_in = 6'd0;
    do_ack();
    bus_write(A_EOI, 32'h0);

    // Withdrawal by mask write while in REQ.
    intr_in = 6'b000001;
    tick(LAT);
    check("wd_req", {31'd0, irq_req}, 32'd1);
    bus_write(A_MASK, 32'h0);
    check("wd_still_req", {31'd0, irq_req}, 32'd1);
    tick(1);
    check("wd_dropped", {31'd0, irq_req}, 32'd0);
    check_rd("wd_vec", A_VEC, 32'd0);
    intr_in = 6'd0;
    bus_write(A_PEND, 32'h3F);
    check_rd("wd_pend_clear", A_PEND, 32'd0);

    // Bus decode: other windows do not touch our registers.
    bus_write(A_MASK, 32'h15);
    bus_write(32'h00007F00, 32'hFF);
    check_rd("decode_mask", A_MASK, 32'h15);
    check_rd("decode_7f10", 32'h00007F10, 32'd0);
    check_rd("eoi_reads0", A_EOI, 32'd0);
    bus_write(A_MASK, 32'h0);

`ifdef IRQC_EDGE_EN
    // Edge capture, set-beats-clear, plain W1C and ack clear.
    intr_in = 6'h08; tick(1);
    intr_in = 6'h00; tick(1);
    check_rd("edge_pulse", A_PEND, 32'h08);
    intr_in = 6'h08;
    bus_write(A_PEND, 32'h08);
    check_rd("set_beats_clr", A_PEND, 32'h08);
    bus_write(A_PEND, 32'h08);
    check_rd("w1c", A_PEND, 32'h00);
    intr_in = 6'h00; tick(1);
    intr_in = 6'h08; tick(1);
    bus_write(A_MASK, 32'h08);
    tick(1);
    check("edge_id3", {29'd0, irq_id}, 32'd3);
    do_ack();
    check_rd("ack_clears", A_PEND, 32'h00);
    bus_write(A_EOI, 32'h0);
    intr_in = 6'h00;
    bus_write(A_MASK, 32'h0);
`endif

    // Reset in the middle of a request.
    bus_write(A_MASK, 32'h10);
    intr_in = 6'h10;
    tick(LAT);
    check("pre_rst_id4", {29'd0, irq_id}, 32'd4);
    #2;
    clr = 1'b0;
    intr_in = 6'd0;
    #1;
    check("rst_req", {31'd0, irq_req}, 32'd0);
    check("rst_id", {29'd0, irq_id}, 32'd0);
    check_rd("rst_mask", A_MASK, 32'd0);
    check_rd("rst_pend", A_PEND, 32'd0);
    check_rd("rst_vec", A_VEC, 32'd0);
    tick(1);
    clr = 1'b1;
    tick(1);

    // Randomized traffic, model checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) intr_in = 6'($urandom_range(0, 63));
      irq_ack = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      case ($urandom_range(0, 7))
        0, 1:    addr = A_MASK;
        2:       addr = A_PEND;
        3:       addr = A_VEC;
        4, 5:    addr = A_EOI;
        6:       addr = 32'h00007F00 + {26'd0, 6'($urandom_range(0, 63))};
        default: addr = $urandom;
      endcase
      if (c % 500 == 250) begin
        #2; clr = 1'b0; #2; clr = 1'b1;
      end
      tick(1);
    end
    irq_ack = 1'b0; we = 1'b0; addr = A_OFF;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Six-source interrupt controller between the peripheral bridge's `intr[5:0]` vector and the CPU. It latches or tracks interrupt sources and applies a software mask. It picks the highest-priority source, lowest index first, and presents it to the CPU through a request/acknowledge handshake. It then holds that source in service until software writes end-of-interrupt. Its registers sit on the same data-bus address/write port as the timers, at a separate 16-byte window.

## Interface
- `N_SRC`, 6, number of interrupt sources; fixed width of `intr_in`, MASK and PEND.
- `BASE`, 32'h00007F20, byte address of register window; window is `BASE`..`BASE+32'hF`.
- `clk` input 1: system clock, all state updates on rising edge.
- `clr` input 1: asynchronous, active-low reset.
- `addr` input 32: bus byte address; register select = `addr[3:2]` when in window.
- `WD` input 32: bus write data.
- `WE` input 1: bus write enable; a write takes effect only when `addr` is in window.
- `RD` output 32: read data, combinational; 0 when `addr` is outside the window.
- `intr_in` input 6: interrupt sources, the bridge `intr` vector, active-high.
- `irq_req` output 1: interrupt request to CPU.
- `irq_id` output 3: index of requested / in-service source.
- `irq_ack` input 1: single-cycle CPU acknowledge.

## Operation
- Registers, by `addr[3:2]`:
  - 0 MASK: RW, bits[5:0]; 1 enables the source. Upper bits read 0.
  - 1 PEND: R, bits[5:0] pending; write behaviour per Configuration.
  - 2 VEC: R, bit31 = FSM in SERVICE, bits[2:0] = `irq_id`. Writes ignored.
  - 3 EOI: write of any value ends service. Reads 0.
- Eligible set `E = PEND & MASK`. Winner = lowest set index of `E`.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if `E != 0` at a rising edge, latch winner into `irq_id` and go to REQ.
  - REQ: `irq_req=1`, `irq_id` held stable.
    - If `irq_ack=1`, go to SERVICE.
    - Else if `E[irq_id]==0` (source withdrawn or masked), go to IDLE.
    - A higher-priority source arriving in REQ does not replace `irq_id`.
  - SERVICE: `irq_req=0`, `irq_id` held. An EOI write returns to IDLE.
- `irq_ack` is ignored in IDLE and SERVICE. EOI writes are ignored in IDLE and REQ.
- No nesting: new sources only accumulate in PEND during SERVICE.
- Reset values: MASK=0, PEND=0, edge-history register=0, state=IDLE, `irq_req=0`, `irq_id=0`. `RD` is combinational from that state.
- Reset mid-handshake aborts immediately (asynchronous); nothing is retained.

## Timing
- Register write takes effect at the rising edge where `WE=1` and `addr` is in window. `RD` reflects it the following cycle.
- IDLE→REQ occurs at the first edge where `E!=0`. `irq_req` is high from that edge until the ack edge.
- Ack latency: REQ→SERVICE at the edge sampling `irq_ack=1`. `irq_req` drops at that same edge.
- EOI and a pending eligible source in the same cycle: SERVICE→IDLE at that edge, IDLE→REQ at the next edge. This is a fixed 1-cycle gap.
- MASK write clearing the requested source while in REQ: request withdrawn at the edge after the write.

## Configuration
- `IRQC_EDGE_EN` defined:
  - Sources are rising-edge detected. The `intr_in` sample is registered.
  - PEND[i] is set at the edge where `intr_in[i]=1` and its previous sample is 0.
  - PEND[`irq_id`] clears at the ack edge.
  - PEND is write-1-to-clear. Set wins over a simultaneous clear of the same bit.
  - Source-to-`irq_req` latency: 2 edges.
- `IRQC_EDGE_EN` undefined:
  - PEND = `intr_in` (level, no storage). PEND writes are ignored. Ack does not clear PEND.
  - Source-to-`irq_req` latency: 1 edge.
  - Software must clear the source in the peripheral before EOI.

## Test plan
- Reset: `clr=0` mid-REQ → `irq_req=0`, `irq_id=0`, reads of MASK/PEND/VEC return 0, immediately and without a clock.
- Priority: MASK=6'h3F; `intr_in` 6'b000000→6'b100100 → `irq_id=2`. Then ack → VEC=32'h80000002; EOI → REQ with `irq_id=5` one cycle later.
- Masking: MASK=6'h01, `intr_in[1]=1` → `irq_req` stays 0 and PEND=6'h02. Then write MASK=6'h03 → `irq_req` rises with `irq_id=1`.
- Withdrawal: in REQ with `irq_id=0`, write MASK=0 → `irq_req` falls, FSM returns to IDLE, VEC=0.
- Edge mode (`IRQC_EDGE_EN`): single 1-cycle pulse on `intr_in[3]` → PEND=6'h08. Ack clears PEND; W1C write of 6'h08 in the same cycle as a new rise on bit 3 → PEND[3] stays 1.
- Bus decode: write 32'hFF to 32'h00007F00 (timer window) → MASK unchanged; read of 32'h00007F10 → `RD=0`.
